// File: rtl/minmax_tracker.sv
// Frame min/max tracker: folds a stream of signed pixels into a running
// maximum, minimum and count, then holds the result until acknowledged.
module minmax_tracker #(
   parameter int NB_PIXEL  = 19,
   parameter int FRAME_LEN = 4096,
   parameter int NB_COUNT  = 13
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_start,
   input  logic                       i_valid,
   input  logic signed [NB_PIXEL-1:0] i_pixel,
   input  logic                       i_ack,
   output logic                       o_ready,
   output logic signed [NB_PIXEL-1:0] o_maxByte,
   output logic signed [NB_PIXEL-1:0] o_minByte,
   output logic                       o_endSignal,
   output logic [NB_COUNT-1:0]        o_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [NB_COUNT-1:0] LAST = NB_COUNT'(FRAME_LEN);
   localparam logic [NB_COUNT-1:0] ONE  = NB_COUNT'(1);
   localparam logic                SINGLE = (FRAME_LEN == 1);

   state_t                state_q, state_d;
   logic signed [NB_PIXEL-1:0] max_d, min_d;
   logic                  end_d;
   logic [NB_COUNT-1:0]   count_d;
   logic [NB_COUNT-1:0]   count_inc;

   assign o_ready   = (state_q != DONE);
   assign count_inc = o_count + ONE;

   always_comb begin
      state_d = state_q;
      max_d   = o_maxByte;
      min_d   = o_minByte;
      end_d   = o_endSignal;
      count_d = o_count;
      if (i_start) begin
         state_d = IDLE;
         end_d   = 1'b0;
         count_d = '0;
         max_d   = '0;
         min_d   = '0;
         // a pixel arriving with start opens the new frame immediately
         if (i_valid) begin
            max_d   = i_pixel;
            min_d   = i_pixel;
            count_d = ONE;
            end_d   = SINGLE;
            state_d = SINGLE ? DONE : TRACK;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_valid) begin
                  max_d   = i_pixel;
                  min_d   = i_pixel;
                  count_d = ONE;
                  end_d   = SINGLE;
                  state_d = SINGLE ? DONE : TRACK;
               end
            end
            TRACK: begin
               if (i_valid) begin
                  if (i_pixel > o_maxByte) max_d = i_pixel;
                  if (i_pixel < o_minByte) min_d = i_pixel;
                  count_d = count_inc;
                  if (count_inc == LAST) begin
                     end_d   = 1'b1;
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (i_ack) begin
                  end_d   = 1'b0;
                  count_d = '0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q     <= IDLE;
         o_maxByte   <= '0;
         o_minByte   <= '0;
         o_endSignal <= 1'b0;
         o_count     <= '0;
      end else begin
         state_q     <= state_d;
         o_maxByte   <= max_d;
         o_minByte   <= min_d;
         o_endSignal <= end_d;
         o_count     <= count_d;
      end
   end

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed vector bench for minmax_tracker with FRAME_LEN=4.
module tb_minmax_tracker;

   localparam int NBP = 19;
   localparam int NBC = 13;

   logic                  clk;
   logic                  rst_n;
   logic                  start;
   logic                  valid;
   logic signed [NBP-1:0] pixel;
   logic                  ack;
   logic                  ready;
   logic signed [NBP-1:0] max_v;
   logic signed [NBP-1:0] min_v;
   logic                  end_s;
   logic [NBC-1:0]        count;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic                  s;
      logic                  v;
      logic signed [NBP-1:0] px;
      logic                  a;
      logic                  rdy;
      logic signed [NBP-1:0] mx;
      logic signed [NBP-1:0] mn;
      logic                  e;
      logic [NBC-1:0]        c;
   } vec_t;

   vec_t tbl[$];

   minmax_tracker #(
      .NB_PIXEL (NBP),
      .FRAME_LEN(4),
      .NB_COUNT (NBC)
   ) dut (
      .i_clock    (clk),
      .i_reset    (rst_n),
      .i_start    (start),
      .i_valid    (valid),
      .i_pixel    (pixel),
      .i_ack      (ack),
      .o_ready    (ready),
      .o_maxByte  (max_v),
      .o_minByte  (min_v),
      .o_endSignal(end_s),
      .o_count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic s, input logic v, input int px,
                      input logic a, input logic rdy, input int mx,
                      input int mn, input logic e, input int c);
      vec_t t;
      t.s   = s;
      t.v   = v;
      t.px  = NBP'(px);
      t.a   = a;
      t.rdy = rdy;
      t.mx  = NBP'(mx);
      t.mn  = NBP'(mn);
      t.e   = e;
      t.c   = NBC'(c);
      tbl.push_back(t);
   endtask

   task automatic post_chk(input string tag, input int mx, input int mn,
                           input logic e, input int c);
      chk({tag, " max"},   int'(max_v), mx);
      chk({tag, " min"},   int'(min_v), mn);
      chk({tag, " end"},   int'(end_s), int'(e));
      chk({tag, " count"}, int'(count), c);
   endtask

   // drive one cycle: o_ready checked before the edge, registers after
   task automatic step(input string tag, input vec_t t);
      start = t.s;
      valid = t.v;
      pixel = t.px;
      ack   = t.a;
      #1;
      chk({tag, " ready"}, int'(ready), int'(t.rdy));
      @(posedge clk);
      #1;
      post_chk(tag, int'(t.mx), int'(t.mn), t.e, int'(t.c));
   endtask

   task automatic px_cycle(input int px);
      start = 1'b0;
      valid = 1'b1;
      pixel = NBP'(px);
      ack   = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      valid = 1'b0;
      pixel = '0;
      ack   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset ready", int'(ready), 1);
      post_chk("reset", 0, 0, 1'b0, 0);
      rst_n = 1'b1;

      // basic frame, then DONE holds against valid
      add(0,1,5,0,       1,5,5,0,1);
      add(0,1,-3,0,      1,5,-3,0,2);
      add(0,1,100,0,     1,100,-3,0,3);
      add(0,1,7,0,       1,100,-3,1,4);
      add(0,1,999,0,     0,100,-3,1,4);
      add(0,1,999,0,     0,100,-3,1,4);
      add(0,1,999,0,     0,100,-3,1,4);
      add(0,0,0,1,       0,100,-3,0,0);
      add(0,1,1,0,       1,1,1,0,1);
      add(0,1,2,0,       1,2,1,0,2);
      add(0,1,3,0,       1,3,1,0,3);
      add(0,1,4,0,       1,4,1,1,4);
      add(0,0,0,1,       0,4,1,0,0);
      // full signed range
      add(0,1,-262144,0, 1,-262144,-262144,0,1);
      add(0,1,262143,0,  1,262143,-262144,0,2);
      add(0,1,0,0,       1,262143,-262144,0,3);
      add(0,1,0,0,       1,262143,-262144,1,4);
      add(0,0,0,1,       0,262143,-262144,0,0);
      // restart with pixel mid-frame
      add(0,1,9,0,       1,9,9,0,1);
      add(0,1,-9,0,      1,9,-9,0,2);
      add(1,1,50,0,      1,50,50,0,1);
      add(0,1,60,0,      1,60,50,0,2);
      add(0,1,70,0,      1,70,50,0,3);
      add(0,1,80,0,      1,80,50,1,4);
      // restart with pixel from DONE, then bare restart
      add(1,1,-7,0,      0,-7,-7,0,1);
      add(1,0,0,0,       1,0,0,0,0);
      // equal values, ack outside DONE ignored
      add(0,1,5,0,       1,5,5,0,1);
      add(0,1,5,0,       1,5,5,0,2);
      add(0,0,0,1,       1,5,5,0,2);
      add(1,0,0,1,       1,0,0,0,0);
      // gapped pixels
      add(0,1,10,0,      1,10,10,0,1);
      add(0,0,0,0,       1,10,10,0,1);
      add(0,0,0,0,       1,10,10,0,1);
      add(0,1,20,0,      1,20,10,0,2);
      add(0,0,0,0,       1,20,10,0,2);
      add(0,0,0,0,       1,20,10,0,2);
      add(0,1,30,0,      1,30,10,0,3);
      add(0,0,0,0,       1,30,10,0,3);
      add(0,0,0,0,       1,30,10,0,3);
      add(0,1,40,0,      1,40,10,1,4);
      add(0,0,0,1,       0,40,10,0,0);

      for (int i = 0; i < tbl.size(); i++)
         step($sformatf("vec%0d", i), tbl[i]);

      // reset in the middle of a frame
      px_cycle(11);
      px_cycle(-22);
      rst_n = 1'b0;
      start = 1'b1;
      valid = 1'b1;
      ack   = 1'b1;
      pixel = NBP'(77);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start = 1'b0;
      valid = 1'b0;
      ack   = 1'b0;
      #1;
      chk("rst ready", int'(ready), 1);
      post_chk("rst", 0, 0, 1'b0, 0);
      px_cycle(3);
      px_cycle(-4);
      px_cycle(8);
      px_cycle(2);
      post_chk("after rst", 8, -4, 1'b1, 4);
      valid = 1'b0;
      #1;
      chk("after rst ready", int'(ready), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/minmax_tracker.md
MINMAX_TRACKER -- requirements
Module: minmax_tracker

Interface
REQ-001 The block SHALL have parameter NB_PIXEL, default 19, giving the signed pixel width.
REQ-002 The block SHALL have parameter FRAME_LEN, default 4096, giving the pixels per frame (legal range 1..2^NB_COUNT-1).
REQ-003 The block SHALL have parameter NB_COUNT, default 13, giving the pixel counter width.
REQ-004 The block SHALL have one clock, i_clock (input, 1), with all state updated on its rising edge.
REQ-005 The block SHALL have reset i_reset (input, 1), which is synchronous and active-low.
REQ-006 The block SHALL have i_start (input, 1): abort any frame in progress and restart.
REQ-007 The block SHALL have i_valid (input, 1): i_pixel carries a pixel this cycle.
REQ-008 The block SHALL have i_pixel (input, NB_PIXEL, signed): pixel value.
REQ-009 The block SHALL have i_ack (input, 1): the downstream rescaler has consumed the result.
REQ-010 The block SHALL have o_ready (output, 1): a pixel is accepted when i_valid and o_ready are both high.
REQ-011 The block SHALL have o_maxByte (output, NB_PIXEL, signed): running or final frame maximum.
REQ-012 The block SHALL have o_minByte (output, NB_PIXEL, signed): running or final frame minimum.
REQ-013 The block SHALL have o_endSignal (output, 1): min and max are final for the frame.
REQ-014 The block SHALL have o_count (output, NB_COUNT): number of pixels accepted in the current frame.

Function
REQ-015 The block SHALL implement three states, IDLE, TRACK and DONE, with all outputs registered except o_ready.
REQ-016 o_ready SHALL be decoded from state: 1 in IDLE and TRACK, 0 in DONE.
REQ-017 In IDLE, an accepted pixel SHALL load o_maxByte=o_minByte=i_pixel and set o_count=1; next state is DONE if FRAME_LEN==1, else TRACK.
REQ-018 In TRACK, an accepted pixel SHALL apply a signed compare: o_maxByte=max(o_maxByte,i_pixel), o_minByte=min(o_minByte,i_pixel), o_count+=1.
REQ-019 In TRACK, when the accepted pixel makes o_count equal FRAME_LEN, the next state SHALL be DONE.
REQ-020 Cycles with i_valid low SHALL change no state, count or data.
REQ-021 Latency: o_maxByte, o_minByte and o_count SHALL reflect an accepted pixel on the following cycle.
REQ-022 o_endSignal SHALL rise on the cycle after the last pixel is accepted.
REQ-023 In DONE, o_endSignal SHALL be held at 1, o_maxByte/o_minByte/o_count SHALL be held stable, and i_valid SHALL be ignored.
REQ-024 In DONE with i_ack=1, the block SHALL go to IDLE, clear o_endSignal and clear o_count to 0 on the next cycle; o_maxByte/o_minByte hold until the next first pixel.
REQ-025 i_ack outside DONE SHALL be ignored.
REQ-026 i_start=1 in any state SHALL take priority over i_ack and in-state pixel handling: go to IDLE, clear o_endSignal, o_count=0, o_maxByte=o_minByte=0.
REQ-027 i_start=1 with i_valid=1 in the same cycle SHALL take the pixel as the first pixel of the new frame (REQ-017 applied), in every state including DONE.
REQ-028 Compares SHALL use the full NB_PIXEL signed range without overflow; equal values leave min/max unchanged.
REQ-029 The counter SHALL never wrap; o_count never exceeds FRAME_LEN.

Reset
REQ-030 While i_reset=0 at a clock edge: state=IDLE, o_endSignal=0, o_count=0, o_maxByte=0, o_minByte=0; o_ready=1 by decode.
REQ-031 Reset SHALL have priority over i_start, i_valid and i_ack, and SHALL discard any partial frame.

Verification (FRAME_LEN=4, NB_PIXEL=19)
REQ-032 The bench SHALL drive pixels 5,-3,100,7 back-to-back -> o_maxByte=100, o_minByte=-3, o_count=4, o_endSignal=1 one cycle after the 4th pixel.
REQ-033 The bench SHALL drive -262144, 262143, 0, 0 -> o_minByte=-262144, o_maxByte=262143.
REQ-034 The bench SHALL hold i_valid=1 with pixel 999 during DONE for 3 cycles -> o_ready=0 and outputs unchanged; then pulse i_ack and drive 1,2,3,4 -> o_maxByte=4, o_minByte=1.
REQ-035 The bench SHALL drive 9,-9, then i_start with i_valid and pixel 50, then 60,70,80 -> o_count=4, o_maxByte=80, o_minByte=50.
REQ-036 The bench SHALL drive 3 pixels separated by i_valid gaps of 2 idle cycles, then a 4th pixel -> o_count steps 1,2,3,4 and o_endSignal rises only after the 4th.
REQ-037 The bench SHALL assert i_reset=0 mid-TRACK after 2 pixels -> the next cycle shows all outputs 0 and IDLE; a new frame then tracks correctly.
